// File: rtl/trans_pkg.sv
// Shared definitions for the transaction-layer flow controller: FSM encoding,
// threshold nibble layout and the state-to-status decode.
package trans_pkg;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   // Each 8-bit threshold input packs {hi, lo} nibbles.
   localparam int THR_W  = 8;
   localparam int LO_LSB = 0;
   localparam int HI_LSB = 4;

   // Returns {error, active, idle}.
   function automatic logic [2:0] status_of(input state_t s);
      status_of = {s == ST_ERROR, s == ST_ACTIVE, s == ST_IDLE};
   endfunction

endpackage

// File: rtl/trans_thresh_cmp.sv
// Unsigned occupancy compare against latched almost-full / almost-empty levels.
module trans_thresh_cmp #(
   parameter int CNT_W = 4
) (
   input  logic [CNT_W-1:0] count,
   input  logic [CNT_W-1:0] lo,
   input  logic [CNT_W-1:0] hi,
   output logic             afull,
   output logic             aempty
);

   assign afull  = count >= hi;
   assign aempty = count <= lo;

endmodule

// File: rtl/trans_flow_ctrl.sv
// Drains the main FIFO into D0/D1 by destination bit, throttled by latched
// thresholds, with a sticky-error block FSM driving registered status.
module trans_flow_ctrl
   import trans_pkg::*;
#(
   parameter int DATA_W   = 6,
   parameter int CNT_W    = 4,
   parameter int DEST_BIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic [THR_W-1:0]  umf_in,
   input  logic [THR_W-1:0]  ud_in,
   input  logic [DATA_W-1:0] main_data,
   input  logic              main_empty,
   input  logic              main_full,
   input  logic              main_push,
   input  logic [CNT_W-1:0]  main_count,
   input  logic [CNT_W-1:0]  d0_count,
   input  logic [CNT_W-1:0]  d1_count,
   input  logic              d0_empty,
   input  logic              d1_empty,
   input  logic              pop_d0,
   input  logic              pop_d1,
   output logic              pop_main,
   output logic              push_d0,
   output logic              push_d1,
   output logic [DATA_W-1:0] data_out,
   output logic              main_afull,
   output logic              main_aempty,
   output logic              d0_afull,
   output logic              d1_afull,
   output logic              idle_out,
   output logic              active_out,
   output logic              error_out
);

   localparam int NUM_CMP = 3;  // 0: main, 1: D0, 2: D1

   state_t                         state;
   logic [THR_W-1:0]               umf_r, ud_r;
   logic                           in_flight;
   logic [NUM_CMP-1:0][CNT_W-1:0]  cmp_cnt, cmp_lo, cmp_hi;
   logic [NUM_CMP-1:0]             afull, aempty;
   logic                           dest_sel, dest_afull, err_cond, go_err;
   logic                           dest_aempty_unused;

   assign cmp_cnt = {d1_count, d0_count, main_count};
   assign cmp_lo  = {ud_r[LO_LSB +: CNT_W], ud_r[LO_LSB +: CNT_W], umf_r[LO_LSB +: CNT_W]};
   assign cmp_hi  = {ud_r[HI_LSB +: CNT_W], ud_r[HI_LSB +: CNT_W], umf_r[HI_LSB +: CNT_W]};

   for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
      trans_thresh_cmp #(.CNT_W(CNT_W)) u_cmp (
         .count  (cmp_cnt[i]),
         .lo     (cmp_lo[i]),
         .hi     (cmp_hi[i]),
         .afull  (afull[i]),
         .aempty (aempty[i])
      );
   end

   assign main_afull  = afull[0];
   assign main_aempty = aempty[0];
   assign d0_afull    = afull[1];
   assign d1_afull    = afull[2];
   // Destination almost-empty levels are latched but have no consumer yet.
   assign dest_aempty_unused = aempty[1] | aempty[2];

   // Head-of-line: only the head word's destination gates the pop.
   assign dest_sel   = main_data[DEST_BIT];
   assign dest_afull = dest_sel ? d1_afull : d0_afull;
   assign pop_main   = (state == ST_ACTIVE) & !main_empty & !dest_afull;

   assign err_cond = (main_push & main_full) | (pop_d0 & d0_empty) | (pop_d1 & d1_empty);
   assign go_err   = (state != ST_RESET) & err_cond;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_RESET;
         umf_r      <= '0;
         ud_r       <= '0;
         data_out   <= '0;
         push_d0    <= 1'b0;
         push_d1    <= 1'b0;
         in_flight  <= 1'b0;
         idle_out   <= 1'b0;
         active_out <= 1'b0;
         error_out  <= 1'b0;
      end else begin
         push_d0   <= pop_main & !dest_sel;
         push_d1   <= pop_main &  dest_sel;
         in_flight <= pop_main;
         if (pop_main) data_out <= main_data;

         // Any init cycle that ends up in INIT reloads the thresholds.
         if (init && state != ST_ERROR && !go_err) begin
            umf_r <= umf_in;
            ud_r  <= ud_in;
         end

         if (go_err) begin
            state <= ST_ERROR;
            {error_out, active_out, idle_out} <= status_of(ST_ERROR);
         end else begin
            case (state)
               ST_RESET: if (init) begin
                  state <= ST_INIT;
                  {error_out, active_out, idle_out} <= status_of(ST_INIT);
               end
               ST_INIT: if (!init) begin
                  state <= ST_IDLE;
                  {error_out, active_out, idle_out} <= status_of(ST_IDLE);
               end
               ST_IDLE: if (init) begin
                  state <= ST_INIT;
                  {error_out, active_out, idle_out} <= status_of(ST_INIT);
               end else if (!main_empty) begin
                  state <= ST_ACTIVE;
                  {error_out, active_out, idle_out} <= status_of(ST_ACTIVE);
               end
               ST_ACTIVE: if (init) begin
                  state <= ST_INIT;
                  {error_out, active_out, idle_out} <= status_of(ST_INIT);
               end else if (main_empty && !in_flight && d0_empty && d1_empty) begin
                  state <= ST_IDLE;
                  {error_out, active_out, idle_out} <= status_of(ST_IDLE);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_trans_flow_ctrl.sv
// Directed bench for trans_flow_ctrl: init, streaming, thresholds, HOL, error, reset.
module tb_trans_flow_ctrl;

   logic       clk, reset, init;
   logic [7:0] umf_in, ud_in;
   logic [5:0] main_data;
   logic       main_empty, main_full, main_push;
   logic [3:0] main_count, d0_count, d1_count;
   logic       d0_empty, d1_empty, pop_d0, pop_d1;
   logic       pop_main, push_d0, push_d1;
   logic [5:0] data_out;
   logic       main_afull, main_aempty, d0_afull, d1_afull;
   logic       idle_out, active_out, error_out;

   int n_tests = 0;
   int n_fail  = 0;

   trans_flow_ctrl dut (
      .clk(clk), .reset(reset), .init(init), .umf_in(umf_in), .ud_in(ud_in),
      .main_data(main_data), .main_empty(main_empty), .main_full(main_full),
      .main_push(main_push), .main_count(main_count), .d0_count(d0_count),
      .d1_count(d1_count), .d0_empty(d0_empty), .d1_empty(d1_empty),
      .pop_d0(pop_d0), .pop_d1(pop_d1), .pop_main(pop_main), .push_d0(push_d0),
      .push_d1(push_d1), .data_out(data_out), .main_afull(main_afull),
      .main_aempty(main_aempty), .d0_afull(d0_afull), .d1_afull(d1_afull),
      .idle_out(idle_out), .active_out(active_out), .error_out(error_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; init = 1'b0; umf_in = 8'h00; ud_in = 8'h00;
      main_data = 6'h00; main_empty = 1'b1; main_full = 1'b0; main_push = 1'b0;
      main_count = 4'd0; d0_count = 4'd0; d1_count = 4'd0;
      d0_empty = 1'b1; d1_empty = 1'b1; pop_d0 = 1'b0; pop_d1 = 1'b0;
      tick(); tick();
      if ({idle_out, active_out, error_out} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b exp 000", {idle_out, active_out, error_out}); end n_tests++;
      if ({push_d0, push_d1, data_out} !== 8'h00) begin n_fail++; $display("FAIL reset_push_data: got %h exp 00", {push_d0, push_d1, data_out}); end n_tests++;
      // thresholds cleared to zero: hi=0 makes every count afull
      if (d0_afull !== 1'b1 || main_aempty !== 1'b1) begin n_fail++; $display("FAIL reset_thresh: got afull=%b aempty=%b exp 1 1", d0_afull, main_aempty); end n_tests++;
      reset = 1'b0;
      tick();
      if ({idle_out, active_out, error_out} !== 3'b000) begin n_fail++; $display("FAIL reset_hold: got %b exp 000", {idle_out, active_out, error_out}); end n_tests++;
   endtask

   task automatic test_init();
      init = 1'b1; umf_in = 8'h30; ud_in = 8'h30;
      tick();
      if (idle_out !== 1'b0) begin n_fail++; $display("FAIL init_state: got idle=%b exp 0", idle_out); end n_tests++;
      init = 1'b0; umf_in = 8'h00; ud_in = 8'h00;
      tick();
      if (idle_out !== 1'b1 || active_out !== 1'b0) begin n_fail++; $display("FAIL init_idle: got idle=%b active=%b exp 1 0", idle_out, active_out); end n_tests++;
      d0_count = 4'd2; #1;
      if (d0_afull !== 1'b0) begin n_fail++; $display("FAIL init_ud_hi_2: got %b exp 0", d0_afull); end n_tests++;
      d0_count = 4'd3; d1_count = 4'd3; #1;
      if (d0_afull !== 1'b1 || d1_afull !== 1'b1) begin n_fail++; $display("FAIL init_ud_hi_3: got %b%b exp 11", d0_afull, d1_afull); end n_tests++;
      main_count = 4'd1; #1;
      if (main_afull !== 1'b0 || main_aempty !== 1'b0) begin n_fail++; $display("FAIL init_umf: got afull=%b aempty=%b exp 0 0", main_afull, main_aempty); end n_tests++;
      main_count = 4'd3; #1;
      if (main_afull !== 1'b1) begin n_fail++; $display("FAIL init_umf_hi: got %b exp 1", main_afull); end n_tests++;
      main_count = 4'd0; d0_count = 4'd0; d1_count = 4'd0;
   endtask

   task automatic test_stream();
      main_empty = 1'b0; main_data = 6'b000000; #1;
      if (pop_main !== 1'b0) begin n_fail++; $display("FAIL stream_idle_nopop: got %b exp 0", pop_main); end n_tests++;
      tick();
      if (active_out !== 1'b1 || pop_main !== 1'b1) begin n_fail++; $display("FAIL stream_pop0: got active=%b pop=%b exp 1 1", active_out, pop_main); end n_tests++;
      tick();
      main_data = 6'b010001; #1;
      if (push_d0 !== 1'b1 || push_d1 !== 1'b0 || data_out !== 6'h00) begin n_fail++; $display("FAIL stream_push_d0: got %b%b data=%h exp 10 data=00", push_d0, push_d1, data_out); end n_tests++;
      if (pop_main !== 1'b1) begin n_fail++; $display("FAIL stream_pop1: got %b exp 1", pop_main); end n_tests++;
      tick();
      main_empty = 1'b1; #1;
      if (push_d0 !== 1'b0 || push_d1 !== 1'b1 || data_out !== 6'h11) begin n_fail++; $display("FAIL stream_push_d1: got %b%b data=%h exp 01 data=11", push_d0, push_d1, data_out); end n_tests++;
      if (pop_main !== 1'b0) begin n_fail++; $display("FAIL stream_empty_nopop: got %b exp 0", pop_main); end n_tests++;
      tick();
      if (push_d1 !== 1'b0 || active_out !== 1'b1) begin n_fail++; $display("FAIL stream_drain: got push_d1=%b active=%b exp 0 1", push_d1, active_out); end n_tests++;
      tick();
      if (idle_out !== 1'b1 || active_out !== 1'b0) begin n_fail++; $display("FAIL stream_back_idle: got idle=%b active=%b exp 1 0", idle_out, active_out); end n_tests++;
   endtask

   task automatic test_threshold();
      main_empty = 1'b0; main_data = 6'h00; d0_count = 4'd3;
      tick();
      if (active_out !== 1'b1 || pop_main !== 1'b0 || d0_afull !== 1'b1) begin n_fail++; $display("FAIL thr_block: got active=%b pop=%b afull=%b exp 1 0 1", active_out, pop_main, d0_afull); end n_tests++;
      d0_count = 4'd2; #1;
      if (pop_main !== 1'b1) begin n_fail++; $display("FAIL thr_release: got %b exp 1", pop_main); end n_tests++;
      d0_count = 4'd3; d1_count = 4'd0; #1;
      if (pop_main !== 1'b0 || d1_afull !== 1'b0) begin n_fail++; $display("FAIL thr_hol: got pop=%b d1_afull=%b exp 0 0", pop_main, d1_afull); end n_tests++;
      tick();
      if (push_d0 !== 1'b0 || push_d1 !== 1'b0) begin n_fail++; $display("FAIL thr_hol_nopush: got %b%b exp 00", push_d0, push_d1); end n_tests++;
   endtask

   task automatic test_error();
      // error and init together: error must win
      main_full = 1'b1; main_push = 1'b1; init = 1'b1;
      tick();
      main_full = 1'b0; main_push = 1'b0; d0_count = 4'd0; #1;
      if (error_out !== 1'b1 || active_out !== 1'b0 || idle_out !== 1'b0) begin n_fail++; $display("FAIL err_set: got err=%b act=%b idle=%b exp 1 0 0", error_out, active_out, idle_out); end n_tests++;
      if (pop_main !== 1'b0) begin n_fail++; $display("FAIL err_nopop: got %b exp 0", pop_main); end n_tests++;
      tick();
      init = 1'b0;
      tick();
      if (error_out !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b exp 1", error_out); end n_tests++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      if (error_out !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b exp 0", error_out); end n_tests++;
   endtask

   task automatic test_reset_midxfer();
      main_empty = 1'b1; main_data = 6'h11; d0_count = 4'd0; d1_count = 4'd0;
      init = 1'b1; umf_in = 8'h30; ud_in = 8'h30;
      tick();
      init = 1'b0;
      tick();
      main_empty = 1'b0;
      tick();
      if (pop_main !== 1'b1) begin n_fail++; $display("FAIL mid_pop: got %b exp 1", pop_main); end n_tests++;
      tick();
      reset = 1'b1;
      if (push_d1 !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: got %b exp 1", push_d1); end n_tests++;
      tick();
      if ({push_d0, push_d1} !== 2'b00 || data_out !== 6'h00) begin n_fail++; $display("FAIL mid_dropped: got %b%b data=%h exp 00 data=00", push_d0, push_d1, data_out); end n_tests++;
      if ({idle_out, active_out, error_out, pop_main} !== 4'b0000) begin n_fail++; $display("FAIL mid_status: got %b exp 0000", {idle_out, active_out, error_out, pop_main}); end n_tests++;
      reset = 1'b0;
      tick();
      if ({push_d0, push_d1, active_out} !== 3'b000) begin n_fail++; $display("FAIL mid_stay_reset: got %b exp 000", {push_d0, push_d1, active_out}); end n_tests++;
   endtask

   initial begin
      test_reset();
      test_init();
      test_stream();
      test_threshold();
      test_error();
      test_reset_midxfer();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
